// File: rtl/pulse_timer_if.sv
// Purpose : control/status bundle between a pulse_timer and the logic that drives it.
// Latency : none; plain wires, no storage.
// Backpressure: none; trig is edge-based and every status output is a live register copy.
// Ports (master = controller side, slave = pulse_timer side):
//   trig, mode, retrig_en, load[W], stop  -> timer
//   prescale[PS_W]                        -> timer, only with PULSE_TIMER_PRESCALE_EN
//   busy, count[W], outpulse              <- timer
interface pulse_timer_if #(
    parameter int W    = 8,
    parameter int PS_W = 4
);
    logic         trig;
    logic         mode;
    logic         retrig_en;
    logic [W-1:0] load;
    logic         stop;
`ifdef PULSE_TIMER_PRESCALE_EN
    logic [PS_W-1:0] prescale;
`endif
    logic         busy;
    logic [W-1:0] count;
    logic         outpulse;

`ifdef PULSE_TIMER_PRESCALE_EN
    modport master (output trig, mode, retrig_en, load, stop, prescale,
                    input  busy, count, outpulse);
    modport slave  (input  trig, mode, retrig_en, load, stop, prescale,
                    output busy, count, outpulse);
`else
    modport master (output trig, mode, retrig_en, load, stop,
                    input  busy, count, outpulse);
    modport slave  (input  trig, mode, retrig_en, load, stop,
                    output busy, count, outpulse);
`endif
endinterface

// File: rtl/pulse_timer.sv
// Purpose : programmable one-shot/periodic delay; a trig rising edge starts a run of
//           load clocks (or ticks), after which outpulse is high for PW clocks.
// Latency : outpulse rises the clock after the terminal edge, load clocks after the start edge.
// Backpressure: none; starts while busy are dropped unless retrig_en or one-shot terminal edge.
// Ports : clk, rst_n (synchronous, active-low), bus (pulse_timer_if.slave):
//         trig/mode/retrig_en/load/stop in, busy/count/outpulse out.
// Option: define PULSE_TIMER_PRESCALE_EN to add bus.prescale; count then advances once
//         every prescale+1 clocks and a run lasts load*(prescale+1) clocks.
module pulse_timer #(
    parameter int W    = 8,
    parameter int PW   = 1,
    parameter int PS_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    pulse_timer_if.slave bus
);
    localparam int           PCW = (PW > 1) ? $clog2(PW) : 1;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t         state_q, state_d;
    logic           trig_q;
    logic           mode_q, mode_d;
    logic [W-1:0]   load_q, load_d;
    logic [W-1:0]   count_q, count_d;
    logic           out_q, out_d;
    logic [PCW-1:0] pcnt_q, pcnt_d;
`ifdef PULSE_TIMER_PRESCALE_EN
    logic [PS_W-1:0] ps_q, ps_d;
    logic [PS_W-1:0] div_q, div_d;
`endif

    logic busy, start, tick, terminal, accept;

    always_comb begin
        busy  = (state_q == ST_RUN);
        start = bus.trig & ~trig_q;
`ifdef PULSE_TIMER_PRESCALE_EN
        tick  = busy & (div_q == ps_q);
`else
        tick  = 1'b1;
`endif
        // load_q is non-zero whenever busy, so the W-bit subtraction cannot wrap here.
        terminal = busy & tick & (count_q == (load_q - ONE));
        // A one-shot's own terminal edge frees the timer, so a start there is taken.
        accept = start & (bus.load != '0) & (~busy | bus.retrig_en | (terminal & ~mode_q));

        state_d = state_q;
        mode_d  = mode_q;
        load_d  = load_q;
        count_d = count_q;
        out_d   = out_q;
        pcnt_d  = pcnt_q;
`ifdef PULSE_TIMER_PRESCALE_EN
        ps_d    = ps_q;
        div_d   = div_q;
`endif

        if (bus.stop) begin
            state_d = ST_IDLE;
            count_d = '0;
            out_d   = 1'b0;
            pcnt_d  = '0;
`ifdef PULSE_TIMER_PRESCALE_EN
            div_d   = '0;
`endif
        end else begin
            // Pulse in flight runs down independently of any restart.
            if (out_q) begin
                if (pcnt_q == '0) out_d = 1'b0;
                else              pcnt_d = pcnt_q - 1'b1;
            end
            // A completed run always issues its pulse; reloading keeps short periods continuous.
            if (terminal) begin
                out_d  = 1'b1;
                pcnt_d = PCW'(PW - 1);
            end

            if (accept) begin
                state_d = ST_RUN;
                mode_d  = bus.mode;
                load_d  = bus.load;
                count_d = '0;
`ifdef PULSE_TIMER_PRESCALE_EN
                ps_d    = bus.prescale;
`endif
            end else if (terminal) begin
                count_d = '0;
                state_d = mode_q ? ST_RUN : ST_IDLE;
            end else if (busy && tick) begin
                count_d = count_q + ONE;
            end

`ifdef PULSE_TIMER_PRESCALE_EN
            if (accept)    div_d = '0;
            else if (busy) div_d = tick ? '0 : div_q + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            trig_q  <= 1'b0;
            mode_q  <= 1'b0;
            load_q  <= '0;
            count_q <= '0;
            out_q   <= 1'b0;
            pcnt_q  <= '0;
`ifdef PULSE_TIMER_PRESCALE_EN
            ps_q    <= '0;
            div_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            trig_q  <= bus.trig;
            mode_q  <= mode_d;
            load_q  <= load_d;
            count_q <= count_d;
            out_q   <= out_d;
            pcnt_q  <= pcnt_d;
`ifdef PULSE_TIMER_PRESCALE_EN
            ps_q    <= ps_d;
            div_q   <= div_d;
`endif
        end
    end

    assign bus.busy     = busy;
    assign bus.count    = count_q;
    assign bus.outpulse = out_q;

endmodule

// File: tb/tb_pulse_timer.sv
// Bench for pulse_timer: two instances (PW=1 and PW=2) share one stimulus stream and
// are compared every clock against a run-length model (elapsed clocks vs run length,
// remaining pulse clocks), followed by directed scenarios and a random stream.
module tb_pulse_timer;
    localparam int W    = 8;
    localparam int PS_W = 4;
    localparam int PW1  = 1;
    localparam int PW2  = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         trig, mode, retrig_en, stop;
    logic [W-1:0] load;
    int           ps;

    always #5 clk = ~clk;

    pulse_timer_if #(.W(W), .PS_W(PS_W)) if1 ();
    pulse_timer_if #(.W(W), .PS_W(PS_W)) if2 ();

    assign if1.trig = trig;  assign if1.mode = mode;  assign if1.retrig_en = retrig_en;
    assign if1.load = load;  assign if1.stop = stop;
    assign if2.trig = trig;  assign if2.mode = mode;  assign if2.retrig_en = retrig_en;
    assign if2.load = load;  assign if2.stop = stop;
`ifdef PULSE_TIMER_PRESCALE_EN
    assign if1.prescale = PS_W'(ps);
    assign if2.prescale = PS_W'(ps);
`endif

    pulse_timer #(.W(W), .PW(PW1), .PS_W(PS_W)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    pulse_timer #(.W(W), .PW(PW2), .PS_W(PS_W)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a run is "elapsed clocks since start" against "run length in clocks".
    bit m_tp;
    int m_busy, m_elapsed, m_len, m_cdiv, m_mode;
    int m_pl1, m_pl2;

    task automatic model_edge();
        bit st, term;
        if (!rst_n) begin
            m_tp = 0; m_busy = 0; m_elapsed = 0; m_len = 0; m_cdiv = 1; m_mode = 0;
            m_pl1 = 0; m_pl2 = 0;
            return;
        end
        st   = trig && !m_tp;
        m_tp = trig;
        if (stop) begin
            m_busy = 0; m_elapsed = 0; m_pl1 = 0; m_pl2 = 0;
            return;
        end
        term = (m_busy != 0) && (m_elapsed + 1 == m_len);
        if (term) begin m_pl1 = PW1; m_pl2 = PW2; end
        else begin
            if (m_pl1 > 0) m_pl1--;
            if (m_pl2 > 0) m_pl2--;
        end
        if (st && load != 0 && (m_busy == 0 || retrig_en || (term && m_mode == 0))) begin
            m_busy = 1; m_elapsed = 0; m_mode = mode;
            m_cdiv = ps + 1;
            m_len  = int'(load) * m_cdiv;
        end else if (term) begin
            m_elapsed = 0; m_busy = m_mode;
        end else if (m_busy != 0) begin
            m_elapsed++;
        end
    endtask

    int stepno, first, npulse;

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("busy1",  int'(if1.busy),     m_busy);
        check("count1", int'(if1.count),    m_elapsed / m_cdiv);
        check("pulse1", int'(if1.outpulse), (m_pl1 > 0) ? 1 : 0);
        check("busy2",  int'(if2.busy),     m_busy);
        check("count2", int'(if2.count),    m_elapsed / m_cdiv);
        check("pulse2", int'(if2.outpulse), (m_pl2 > 0) ? 1 : 0);
        stepno++;
        if (if1.outpulse) begin
            npulse++;
            if (first < 0) first = stepno;
        end
    endtask

    task automatic idle(input int n);
        trig = 1'b0;
        repeat (n) tick();
    endtask

    // Start edge is step 0; later steps are numbered by clocks after it.
    task automatic fire(input int ld, input bit md);
        load = W'(ld); mode = md; trig = 1'b1;
        stepno = -1; first = -1; npulse = 0;
        tick();
        trig = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; trig = 1'b0; mode = 1'b0; retrig_en = 1'b0; stop = 1'b0;
        load = '0; ps = 0;
        m_cdiv = 1;
        stepno = 0; first = -1; npulse = 0;

        // Reset held with trig toggling, then release with no spurious pulse.
        load = 8'd3;
        repeat (3) begin trig = ~trig; tick(); end
        trig = 1'b0; rst_n = 1'b1; npulse = 0;
        idle(5);
        check("reset_npulse", npulse, 0);

        // One-shot, load 5.
        fire(5, 0); idle(10);
        check("os_first", first, 5);
        check("os_npulse", npulse, 1);

        // Periodic, load 4, stop on step 10.
        fire(4, 1); idle(9);
        stop = 1'b1; tick(); stop = 1'b0;
        check("per_first", first, 4);
        check("per_npulse", npulse, 2);
        idle(5);

        // Retrigger on step 3, with and without retrig_en.
        retrig_en = 1'b1;
        fire(6, 0); idle(2); trig = 1'b1; tick(); idle(10);
        check("rt1_first", first, 9);
        check("rt1_npulse", npulse, 1);
        retrig_en = 1'b0;
        fire(6, 0); idle(2); trig = 1'b1; tick(); idle(10);
        check("rt0_first", first, 6);
        check("rt0_npulse", npulse, 1);

        // Boundaries.
        fire(0, 0); idle(5);
        check("ld0_npulse", npulse, 0);
        fire(1, 0); idle(3);
        check("ld1_first", first, 1);
        fire(255, 0); idle(260);
        check("ld255_first", first, 255);
        check("ld255_npulse", npulse, 1);
        fire(3, 0); idle(2); trig = 1'b1; tick(); idle(6);
        check("b2b_first", first, 3);
        check("b2b_npulse", npulse, 2);
        stop = 1'b1; fire(5, 0); stop = 1'b0; idle(8);
        check("stopstart_npulse", npulse, 0);

`ifdef PULSE_TIMER_PRESCALE_EN
        ps = 2;
        fire(3, 0); idle(12);
        check("ps_first", first, 9);
        ps = 0;
`endif

        // Reset mid-run clears everything on the next edge.
        fire(20, 1); idle(5);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        idle(3);

        // Random stream.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) trig = ~trig;
            load      = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, 12));
            mode      = 1'($urandom_range(0, 1));
            retrig_en = 1'($urandom_range(0, 1));
            stop      = ($urandom_range(0, 39) == 0);
            rst_n     = ($urandom_range(0, 149) != 0);
`ifdef PULSE_TIMER_PRESCALE_EN
            ps        = $urandom_range(0, 3);
`endif
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
